// File: rtl/bist_ctrl.sv
// Purpose : BIST sequencer - clears/enables the TPG, compacts CUT responses in a MISR, checks the golden signature.
// Latency : start sampled at edge k -> busy after k+1, done after k+N_PATTERNS+3; outputs trail the state by one edge.
// Backpressure: none; start is a level request honoured only in IDLE/DONE, abort wins over start at any time.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   start      level run request (sampled in IDLE and DONE)
//   abort      synchronous abort back to IDLE, clears signature/count/pass
//   resp       CUT response for the current pattern
//   tpg_clr    pattern generator clear, one cycle per run
//   tpg_en     pattern generator enable, N_PATTERNS cycles per run
//   busy       run in progress (INIT/RUN/COMPARE)
//   done       run finished, pass valid
//   pass       result of the last signature compare
//   sig_out    (BIST_SIG_OUT_EN only) live MISR contents
//   fail_pulse (BIST_SIG_OUT_EN only) one-cycle strobe when a compare fails
//
// Build option: define BIST_SIG_OUT_EN to expose sig_out and fail_pulse.
module bist_ctrl #(
    parameter int              N_PATTERNS = 15,
    parameter int              WIDTH      = 4,
    parameter logic [WIDTH-1:0] GOLDEN    = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] resp,
`ifdef BIST_SIG_OUT_EN
    output logic [WIDTH-1:0] sig_out,
    output logic             fail_pulse,
`endif
    output logic             tpg_clr,
    output logic             tpg_en,
    output logic             busy,
    output logic             done,
    output logic             pass
);

    localparam int             CW   = $clog2(N_PATTERNS + 1);
    localparam logic [CW-1:0]  LAST = CW'(N_PATTERNS - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_INIT = 3'd1,
        S_RUN  = 3'd2,
        S_CMP  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sig_q, sig_d;
    logic [CW-1:0]    count_q, count_d;
    logic             pass_q, pass_d;
    logic             tpg_clr_q, tpg_clr_d;
    logic             tpg_en_q, tpg_en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             fail_q, fail_d;
    logic [WIDTH-1:0] misr_nxt;

    // MISR: shift left, feedback of the MSB into taps 0 and 1, response folded in on every bit.
    always_comb begin
        misr_nxt    = '0;
        misr_nxt[0] = sig_q[WIDTH-1] ^ resp[0];
        misr_nxt[1] = sig_q[0] ^ sig_q[WIDTH-1] ^ resp[1];
        for (int i = 2; i < WIDTH; i++) begin
            misr_nxt[i] = sig_q[i-1] ^ resp[i];
        end
    end

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        count_d = count_q;
        pass_d  = pass_q;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_INIT;
            end
            S_INIT: begin
                sig_d   = '0;
                count_d = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                sig_d   = misr_nxt;
                count_d = count_q + CW'(1);
                if (count_q == LAST) state_d = S_CMP;
            end
            S_CMP: begin
                pass_d  = (sig_q == GOLDEN);
                state_d = S_DONE;
            end
            S_DONE: begin
                if (start) state_d = S_INIT;
            end
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d = S_IDLE;
            sig_d   = '0;
            count_d = '0;
            pass_d  = 1'b0;
        end
    end

    // Output flops decode the current state; abort forces them low on the same edge
    // that takes the FSM back to IDLE so the TPG stops immediately.
    always_comb begin
        tpg_clr_d = !abort && (state_q == S_INIT);
        tpg_en_d  = !abort && (state_q == S_RUN);
        busy_d    = !abort && ((state_q == S_INIT) || (state_q == S_RUN) || (state_q == S_CMP));
        done_d    = !abort && (state_q == S_DONE);
        fail_d    = !abort && (state_q == S_CMP) && (sig_q != GOLDEN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            sig_q     <= '0;
            count_q   <= '0;
            pass_q    <= 1'b0;
            tpg_clr_q <= 1'b0;
            tpg_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sig_q     <= sig_d;
            count_q   <= count_d;
            pass_q    <= pass_d;
            tpg_clr_q <= tpg_clr_d;
            tpg_en_q  <= tpg_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            fail_q    <= fail_d;
        end
    end

    assign tpg_clr = tpg_clr_q;
    assign tpg_en  = tpg_en_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign pass    = pass_q;

`ifdef BIST_SIG_OUT_EN
    assign sig_out    = sig_q;
    assign fail_pulse = fail_q;
`else
    // fail_q has no consumer without the debug ports; keep it tied into a used net.
    logic unused_fail;
    assign unused_fail = fail_q;
`endif

endmodule

// File: tb/tb_bist_ctrl.sv
// Purpose : self-checking bench for bist_ctrl, four parameterisations side by side.
// Latency : a reference model tracks each run by position (idle/init/run k/compare/done).
// Backpressure: n/a.
module tb_bist_ctrl;

    localparam int NI = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [3:0] resp [NI];

    logic       clr [NI];
    logic       en  [NI];
    logic       bsy [NI];
    logic       dn  [NI];
    logic       ps  [NI];
`ifdef BIST_SIG_OUT_EN
    logic [3:0] so  [NI];
    logic       fp  [NI];
`endif

    int         n_checks = 0;
    int         n_errors = 0;

    int         np  [NI];
    logic [3:0] gd  [NI];

    // reference model
    int         pos   [NI];   // -1 idle, 0 init, 1..N run, N+1 compare, N+2 done
    logic [3:0] msig  [NI];
    logic       mpass [NI];
    logic       e_clr [NI];
    logic       e_en  [NI];
    logic       e_bsy [NI];
    logic       e_dn  [NI];
    logic       e_ps  [NI];
    logic       e_fp  [NI];

    always #5 clk = ~clk;

    bist_ctrl #(.N_PATTERNS(15), .WIDTH(4), .GOLDEN(4'h0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .resp(resp[0]),
`ifdef BIST_SIG_OUT_EN
        .sig_out(so[0]), .fail_pulse(fp[0]),
`endif
        .tpg_clr(clr[0]), .tpg_en(en[0]), .busy(bsy[0]), .done(dn[0]), .pass(ps[0])
    );

    bist_ctrl #(.N_PATTERNS(2), .WIDTH(4), .GOLDEN(4'h3)) dut1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .resp(resp[1]),
`ifdef BIST_SIG_OUT_EN
        .sig_out(so[1]), .fail_pulse(fp[1]),
`endif
        .tpg_clr(clr[1]), .tpg_en(en[1]), .busy(bsy[1]), .done(dn[1]), .pass(ps[1])
    );

    bist_ctrl #(.N_PATTERNS(2), .WIDTH(4), .GOLDEN(4'h1)) dut2 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .resp(resp[2]),
`ifdef BIST_SIG_OUT_EN
        .sig_out(so[2]), .fail_pulse(fp[2]),
`endif
        .tpg_clr(clr[2]), .tpg_en(en[2]), .busy(bsy[2]), .done(dn[2]), .pass(ps[2])
    );

    bist_ctrl #(.N_PATTERNS(1), .WIDTH(4), .GOLDEN(4'h5)) dut3 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .resp(resp[3]),
`ifdef BIST_SIG_OUT_EN
        .sig_out(so[3]), .fail_pulse(fp[3]),
`endif
        .tpg_clr(clr[3]), .tpg_en(en[3]), .busy(bsy[3]), .done(dn[3]), .pass(ps[3])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Signature update as shift-and-xor-polynomial arithmetic.
    function automatic logic [3:0] misr_ref(input logic [3:0] s, input logic [3:0] r);
        logic [3:0] v;
        v = {s[2:0], 1'b0} ^ r;
        if (s[3]) v = v ^ 4'b0011;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            pos[i] = -1; msig[i] = 4'h0; mpass[i] = 1'b0;
            e_clr[i] = 1'b0; e_en[i] = 1'b0; e_bsy[i] = 1'b0;
            e_dn[i] = 1'b0; e_ps[i] = 1'b0; e_fp[i] = 1'b0;
        end
    endtask

    // One clock edge of every model instance; uses the inputs held across the edge.
    task automatic model_step();
        for (int i = 0; i < NI; i++) begin
            int n;
            n = np[i];
            if (abort) begin
                pos[i] = -1; msig[i] = 4'h0; mpass[i] = 1'b0;
                e_clr[i] = 1'b0; e_en[i] = 1'b0; e_bsy[i] = 1'b0;
                e_dn[i] = 1'b0; e_ps[i] = 1'b0; e_fp[i] = 1'b0;
            end else begin
                e_clr[i] = (pos[i] == 0);
                e_en[i]  = (pos[i] >= 1) && (pos[i] <= n);
                e_bsy[i] = (pos[i] >= 0) && (pos[i] <= n + 1);
                e_dn[i]  = (pos[i] == n + 2);
                e_fp[i]  = (pos[i] == n + 1) && (msig[i] != gd[i]);
                if (pos[i] == n + 1) mpass[i] = (msig[i] == gd[i]);
                e_ps[i] = mpass[i];
                if (pos[i] == -1) begin
                    pos[i] = start ? 0 : -1;
                end else if (pos[i] == 0) begin
                    msig[i] = 4'h0;
                    pos[i]  = 1;
                end else if (pos[i] <= n) begin
                    msig[i] = misr_ref(msig[i], resp[i]);
                    pos[i]  = pos[i] + 1;
                end else if (pos[i] == n + 1) begin
                    pos[i] = n + 2;
                end else begin
                    pos[i] = start ? 0 : n + 2;
                end
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NI; i++) begin
            check($sformatf("tpg_clr[%0d]", i), 32'(clr[i]), 32'(e_clr[i]));
            check($sformatf("tpg_en[%0d]", i),  32'(en[i]),  32'(e_en[i]));
            check($sformatf("busy[%0d]", i),    32'(bsy[i]), 32'(e_bsy[i]));
            check($sformatf("done[%0d]", i),    32'(dn[i]),  32'(e_dn[i]));
            check($sformatf("pass[%0d]", i),    32'(ps[i]),  32'(e_ps[i]));
`ifdef BIST_SIG_OUT_EN
            check($sformatf("sig_out[%0d]", i),    32'(so[i]), 32'(msig[i]));
            check($sformatf("fail_pulse[%0d]", i), 32'(fp[i]), 32'(e_fp[i]));
`endif
        end
    endtask

    // Inputs are changed at the falling edge; outputs checked at the next falling edge.
    task automatic tick();
        @(posedge clk);
        if (rst) model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic mid_reset();
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        check_all();
        rst = 1'b1;
    endtask

    initial begin
        int t_busy, t_clr, t_done, en_cnt, clr_cnt;

        np = '{15, 2, 2, 1};
        gd = '{4'h0, 4'h3, 4'h1, 4'h5};
        rst = 1'b0; start = 1'b1; abort = 1'b0;
        for (int i = 0; i < NI; i++) resp[i] = 4'h0;
        model_reset();

        // reset held with start high: everything stays quiet
        @(negedge clk);
        check_all();
        for (int c = 0; c < 3; c++) tick();

        // release with start high; first sampled edge is t=0
        rst = 1'b1;
        tick();
        start = 1'b0;
        resp[0] = 4'h0; resp[1] = 4'h1; resp[2] = 4'h1; resp[3] = 4'h6;
        t_busy = -1; t_clr = -1; t_done = -1; en_cnt = 0; clr_cnt = 0;
        for (int t = 1; t <= 24; t++) begin
            tick();
            if (bsy[0] && t_busy < 0) t_busy = t;
            if (clr[0] && t_clr < 0) t_clr = t;
            if (dn[0] && t_done < 0) t_done = t;
            if (en[0]) en_cnt++;
            if (clr[0]) clr_cnt++;
        end
        check("busy_latency", 32'(t_busy), 32'd1);
        check("clr_latency", 32'(t_clr), 32'd1);
        check("clr_cycles", 32'(clr_cnt), 32'd1);
        check("en_cycles", 32'(en_cnt), 32'd15);
        check("done_latency", 32'(t_done), 32'd18);
        check("pass_zero_resp", 32'(ps[0]), 32'd1);
        check("pass_n2_golden3", 32'(ps[1]), 32'd1);
        check("pass_n2_golden1", 32'(ps[2]), 32'd0);
        check("pass_n1_golden5", 32'(ps[3]), 32'd0);

        // start held high: back-to-back reruns out of DONE
        start = 1'b1;
        for (int c = 0; c < 45; c++) tick();
        start = 1'b0;
        for (int c = 0; c < 24; c++) tick();

        // abort on the third RUN cycle
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", 32'(bsy[0]), 32'd0);
        check("abort_en", 32'(en[0]), 32'd0);
        check("abort_pass", 32'(ps[0]), 32'd0);
        tick();

        // full run afterwards, with start re-pulsed mid-run
        start = 1'b1;
        tick();
        start = 1'b0;
        en_cnt = 0; t_done = -1;
        for (int t = 1; t <= 24; t++) begin
            start = (t == 6);
            tick();
            if (en[0]) en_cnt++;
            if (dn[0] && t_done < 0) t_done = t;
        end
        start = 1'b0;
        check("rerun_en_cycles", 32'(en_cnt), 32'd15);
        check("rerun_done_latency", 32'(t_done), 32'd18);

        // abort and start together never leave IDLE
        abort = 1'b1; start = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("abort_start_clr", 32'(clr[0]), 32'd0);
            check("abort_start_busy", 32'(bsy[0]), 32'd0);
        end
        abort = 1'b0; start = 1'b0;
        tick();

        // randomized traffic with occasional asynchronous reset
        for (int c = 0; c < 3000; c++) begin
            start = ($urandom_range(0, 7) == 0);
            abort = ($urandom_range(0, 59) == 0);
            for (int i = 0; i < NI; i++)
                resp[i] = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 499) == 0) mid_reset();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bist_ctrl.md
Name: bist_ctrl

Overview:
- Sequencing controller for the BIST datapath.
- Clears and enables the pattern generator and counts the applied patterns.
- Compacts the circuit-under-test (CUT) response into an internal MISR, compares the final signature against a golden value and reports done/pass.
- Sits between the top-level test request and the tpg → CUT chain.

Parameters:
- N_PATTERNS, 15, number of patterns applied per run (1..255).
- WIDTH, 4, response and signature width (≥2).
- GOLDEN, 4'h0, expected final signature (WIDTH bits).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  level request to begin a run; sampled in IDLE and DONE.
- abort  input  1  synchronous abort; returns to IDLE.
- resp  input  WIDTH  CUT response to the current pattern.
- tpg_clr  output  1  active-high clear to the pattern generator; high for exactly the INIT cycle.
- tpg_en  output  1  pattern generator enable; high in RUN only.
- busy  output  1  high in INIT, RUN and COMPARE.
- done  output  1  high in DONE.
- pass  output  1  result of the last compare; valid while done=1.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, count=0, sig=0.
  - tpg_clr=0, tpg_en=0, busy=0, done=0, pass=0.
- All outputs are registered, decoded from the state register. No combinational path from inputs to outputs.
- States and transitions:
  - IDLE: start=1 → INIT.
  - INIT (1 cycle): tpg_clr=1, sig←0, count←0 → RUN.
  - RUN (N_PATTERNS cycles):
    - tpg_en=1.
    - Each cycle: sig←misr(sig,resp), count←count+1.
    - count==N_PATTERNS-1 → COMPARE.
  - COMPARE (1 cycle): pass←(sig==GOLDEN) → DONE.
  - DONE: done=1, pass held. start=1 → INIT (rerun); otherwise stay.
- MISR update, with fb=sig[WIDTH-1]:
  - nxt[0]=fb^resp[0]
  - nxt[1]=sig[0]^fb^resp[1]
  - nxt[i]=sig[i-1]^resp[i] for i≥2
- Latency: start seen at edge k → busy at k+1; done at k+N_PATTERNS+3.
- Counter width: $clog2(N_PATTERNS+1). No wrap occurs; the terminal compare is exact equality.
- start during INIT/RUN/COMPARE is ignored. Holding start high in DONE reruns back-to-back.
- abort=1 in any state:
  - Next state IDLE; sig, count, pass cleared; tpg_en, tpg_clr dropped next edge.
  - abort has priority over start in the same cycle.
- N_PATTERNS=1: RUN lasts exactly one cycle.
- rst asserted mid-run: immediate return to reset values regardless of state.
- Unused state encodings → IDLE.

Optional Feature:
- Macro: BIST_SIG_OUT_EN.
- Defined:
  - Adds output port sig_out [WIDTH-1:0] = internal signature register (registered, live in all states).
  - Adds output fail_pulse: one-cycle high on the COMPARE→DONE edge when the compare fails.
- Undefined: neither port exists; signature observable only via pass.

Test Plan:
- Reset: rst=0 with start=1 → all outputs 0, state stays IDLE until rst=1 and start sampled; first tpg_clr one cycle after rst release plus start.
- Default params, resp held 4'h0, GOLDEN=0, start pulse → tpg_clr high 1 cycle, tpg_en high exactly 15 cycles, done at start-edge+18, pass=1.
- N_PATTERNS=2, resp held 4'b0001, GOLDEN=4'b0011 → sig 0001 then 0011, pass=1; same run with GOLDEN=4'b0001 → pass=0 (fail_pulse=1 when BIST_SIG_OUT_EN).
- abort=1 on third RUN cycle → next cycle busy=0, tpg_en=0, state IDLE, pass=0; new start performs full 15-pattern run.
- start re-pulsed during RUN → ignored, run length unchanged; start held high in DONE → INIT next cycle, tpg_clr=1, done=0.
- abort and start both high in IDLE → remains IDLE, no tpg_clr.
